// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a synchronous program ROM and registers instruction/address pairs for decode.
// Define FETCH_STAGE_INT_EN to build the interrupt accept/return logic; without it int_req and int_done are ignored.
module fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [9:0]  redirect_addr,
  input  logic        int_req,
  input  logic        int_done,
  input  logic [17:0] rom_instr,
  output logic [9:0]  rom_address,
  output logic [17:0] instr_out,
  output logic [9:0]  addr_out,
  output logic        valid_out,
  output logic        int_ack,
  output logic [9:0]  int_ret_addr
);

  // Handshake: no valid/ready pair here; valid_out qualifies instr_out/addr_out
  // every cycle, and stall freezes them so decode sees the same pair again.
  typedef enum logic [1:0] {
    ST_FILL       = 2'd0,
    ST_RUN        = 2'd1,
    ST_INT_ACTIVE = 2'd2
  } state_t;

  localparam logic [9:0] INT_VECTOR = 10'h3FF;

  state_t      state_q, state_d;
  logic [9:0]  fetch_pc_q, fetch_pc_d;
  logic [9:0]  pc_delay_q, pc_delay_d;
  logic [17:0] instr_q, instr_d;
  logic [9:0]  addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        int_ack_q, int_ack_d;
  logic [9:0]  int_ret_q, int_ret_d;
  logic        int_accept;
  logic        int_return;

`ifdef FETCH_STAGE_INT_EN
  assign int_accept = (state_q == ST_RUN) && int_req && !redirect;
  assign int_return = (state_q == ST_INT_ACTIVE) && int_done;
`else
  logic unused_int;
  assign unused_int = int_req ^ int_done;
  assign int_accept = 1'b0;
  assign int_return = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pc_delay_d  = pc_delay_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    int_ack_d   = 1'b0;
    int_ret_d   = int_ret_q;
    rom_address = fetch_pc_q;

    if (state_q == ST_FILL) begin
      // Prime the ROM pipeline; control inputs are not honoured yet.
      valid_d    = 1'b0;
      pc_delay_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 10'd1;
      state_d    = ST_RUN;
    end else begin
      if (int_return) state_d = ST_RUN;
      if (redirect) begin
        rom_address = redirect_addr;
        valid_d     = 1'b0;
        pc_delay_d  = redirect_addr;
        fetch_pc_d  = redirect_addr + 10'd1;
      end else if (int_accept) begin
        // pc_delay is the oldest not-yet-issued address, so it is the resume point.
        rom_address = INT_VECTOR;
        int_ack_d   = 1'b1;
        int_ret_d   = pc_delay_q;
        valid_d     = 1'b0;
        pc_delay_d  = INT_VECTOR;
        fetch_pc_d  = INT_VECTOR + 10'd1;
        state_d     = ST_INT_ACTIVE;
      end else if (stall) begin
        // Re-read the word already on rom_instr so it is still there on release.
        rom_address = pc_delay_q;
      end else begin
        instr_d    = rom_instr;
        addr_d     = pc_delay_q;
        valid_d    = 1'b1;
        pc_delay_d = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      fetch_pc_q <= 10'd0;
      pc_delay_q <= 10'd0;
      instr_q    <= 18'd0;
      addr_q     <= 10'd0;
      valid_q    <= 1'b0;
      int_ack_q  <= 1'b0;
      int_ret_q  <= 10'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_delay_q <= pc_delay_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      int_ack_q  <= int_ack_d;
      int_ret_q  <= int_ret_d;
    end
  end

  assign instr_out    = instr_q;
  assign addr_out     = addr_q;
  assign valid_out    = valid_q;
  assign int_ack      = int_ack_q;
  assign int_ret_addr = int_ret_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a stimulus table plus hand-written interrupt and reset sequences.
// The behavioural ROM returns its own address as the instruction word.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [9:0]  redirect_addr;
  logic        int_req;
  logic        int_done;
  logic [17:0] rom_instr;
  logic [9:0]  rom_address;
  logic [17:0] instr_out;
  logic [9:0]  addr_out;
  logic        valid_out;
  logic        int_ack;
  logic [9:0]  int_ret_addr;

  int n_chk;
  int n_fail;
  logic [9:0] exp_q[$];

  typedef struct {
    logic       stall;
    logic       redirect;
    logic [9:0] ra;
    logic       ir;
    logic       id;
    logic [9:0] exp_rom;
    logic       exp_valid;
    logic [9:0] exp_addr;
    logic       exp_ack;
    logic [9:0] exp_ret;
  } vec_t;

  vec_t vecs[20];

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .int_req       (int_req),
    .int_done      (int_done),
    .rom_instr     (rom_instr),
    .rom_address   (rom_address),
    .instr_out     (instr_out),
    .addr_out      (addr_out),
    .valid_out     (valid_out),
    .int_ack       (int_ack),
    .int_ret_addr  (int_ret_addr)
  );

  // Clock / reset block and ROM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rom_instr = 18'd0;
  always @(posedge clk) rom_instr <= {8'h00, rom_address};

  function automatic vec_t mk(input logic s, input logic r, input logic [9:0] ra,
                              input logic ir, input logic id, input logic [9:0] rom,
                              input logic v, input logic [9:0] a, input logic ack,
                              input logic [9:0] ret);
    vec_t t;
    t.stall = s; t.redirect = r; t.ra = ra; t.ir = ir; t.id = id;
    t.exp_rom = rom; t.exp_valid = v; t.exp_addr = a; t.exp_ack = ack; t.exp_ret = ret;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: entered just after a falling edge, leaves just after the next one.
  task automatic step(input vec_t v, input string tag);
    stall = v.stall; redirect = v.redirect; redirect_addr = v.ra;
    int_req = v.ir; int_done = v.id;
    #1;
    chk({tag, " rom_address"}, 32'(rom_address), 32'(v.exp_rom));
    @(posedge clk);
    #1;
    chk({tag, " valid_out"}, 32'(valid_out), 32'(v.exp_valid));
    chk({tag, " addr_out"}, 32'(addr_out), 32'(v.exp_addr));
    chk({tag, " instr_out"}, 32'(instr_out), 32'({8'h00, v.exp_addr}));
    chk({tag, " int_ack"}, 32'(int_ack), 32'(v.exp_ack));
    chk({tag, " int_ret_addr"}, 32'(int_ret_addr), 32'(v.exp_ret));
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " rst valid_out"}, 32'(valid_out), 32'd0);
    chk({tag, " rst addr_out"}, 32'(addr_out), 32'd0);
    chk({tag, " rst instr_out"}, 32'(instr_out), 32'd0);
    chk({tag, " rst int_ack"}, 32'(int_ack), 32'd0);
    chk({tag, " rst int_ret_addr"}, 32'(int_ret_addr), 32'd0);
    chk({tag, " rst rom_address"}, 32'(rom_address), 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = 10'd0;
    int_req = 1'b0; int_done = 1'b0;

    // Fill edge ignores stall/redirect; stall window at addr 5; redirect under stall; wrap at 0x3FF.
    vecs[0]  = mk(1, 1, 10'h155, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000);
    vecs[1]  = mk(0, 0, 10'h000, 0, 0, 10'h001, 1, 10'h000, 0, 10'h000);
    vecs[2]  = mk(0, 0, 10'h000, 0, 0, 10'h002, 1, 10'h001, 0, 10'h000);
    vecs[3]  = mk(0, 0, 10'h000, 0, 0, 10'h003, 1, 10'h002, 0, 10'h000);
    vecs[4]  = mk(0, 0, 10'h000, 0, 0, 10'h004, 1, 10'h003, 0, 10'h000);
    vecs[5]  = mk(0, 0, 10'h000, 0, 0, 10'h005, 1, 10'h004, 0, 10'h000);
    vecs[6]  = mk(0, 0, 10'h000, 0, 0, 10'h006, 1, 10'h005, 0, 10'h000);
    vecs[7]  = mk(1, 0, 10'h000, 0, 0, 10'h006, 1, 10'h005, 0, 10'h000);
    vecs[8]  = mk(1, 0, 10'h000, 0, 0, 10'h006, 1, 10'h005, 0, 10'h000);
    vecs[9]  = mk(1, 0, 10'h000, 0, 0, 10'h006, 1, 10'h005, 0, 10'h000);
    vecs[10] = mk(0, 0, 10'h000, 0, 0, 10'h007, 1, 10'h006, 0, 10'h000);
    vecs[11] = mk(0, 0, 10'h000, 0, 0, 10'h008, 1, 10'h007, 0, 10'h000);
    vecs[12] = mk(1, 1, 10'h120, 0, 0, 10'h120, 0, 10'h007, 0, 10'h000);
    vecs[13] = mk(0, 0, 10'h000, 0, 0, 10'h121, 1, 10'h120, 0, 10'h000);
    vecs[14] = mk(0, 0, 10'h000, 0, 0, 10'h122, 1, 10'h121, 0, 10'h000);
    vecs[15] = mk(0, 1, 10'h3FE, 0, 0, 10'h3FE, 0, 10'h121, 0, 10'h000);
    vecs[16] = mk(0, 0, 10'h000, 0, 0, 10'h3FF, 1, 10'h3FE, 0, 10'h000);
    vecs[17] = mk(0, 0, 10'h000, 0, 0, 10'h000, 1, 10'h3FF, 0, 10'h000);
    vecs[18] = mk(0, 0, 10'h000, 0, 0, 10'h001, 1, 10'h000, 0, 10'h000);
    vecs[19] = mk(0, 0, 10'h000, 0, 1, 10'h002, 1, 10'h001, 0, 10'h000);

    repeat (3) @(negedge clk);
    chk_reset_state("init");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(vecs[i], $sformatf("vec%0d", i));

`ifdef FETCH_STAGE_INT_EN
    // Accept at pc_delay 0x040, held int_req ignored in INT_ACTIVE, re-accept after int_done (under stall).
    step(mk(0, 1, 10'h040, 0, 0, 10'h040, 0, 10'h001, 0, 10'h000), "int_redir");
    step(mk(0, 0, 10'h000, 1, 0, 10'h3FF, 0, 10'h001, 1, 10'h040), "int_acc");
    step(mk(0, 0, 10'h000, 1, 0, 10'h000, 1, 10'h3FF, 0, 10'h040), "int_run0");
    step(mk(0, 0, 10'h000, 1, 0, 10'h001, 1, 10'h000, 0, 10'h040), "int_run1");
    step(mk(0, 0, 10'h000, 1, 0, 10'h002, 1, 10'h001, 0, 10'h040), "int_run2");
    step(mk(0, 0, 10'h000, 1, 0, 10'h003, 1, 10'h002, 0, 10'h040), "int_run3");
    step(mk(0, 0, 10'h000, 1, 1, 10'h004, 1, 10'h003, 0, 10'h040), "int_done");
    step(mk(1, 0, 10'h000, 1, 0, 10'h3FF, 0, 10'h003, 1, 10'h004), "int_acc2");
    step(mk(0, 0, 10'h000, 0, 1, 10'h000, 1, 10'h3FF, 0, 10'h004), "int_ret2");
`else
    // Level int_req for 20 cycles must not disturb sequential fetch.
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back(10'(2 + k));
      step(mk(0, 0, 10'h000, 1, (k % 5) == 0, 10'(3 + k), 1, exp_q.pop_front(), 0, 10'h000),
           $sformatf("noint%0d", k));
    end
`endif

    // Reset asserted with stall and redirect pending must clear everything at once.
    stall = 1'b1; redirect = 1'b1; redirect_addr = 10'h2AA; int_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid");
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(0, 0, 10'h000, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000), "rel_fill");
    step(mk(0, 0, 10'h000, 0, 0, 10'h001, 1, 10'h000, 0, 10'h000), "rel_first");
    step(mk(0, 0, 10'h000, 0, 0, 10'h002, 1, 10'h001, 0, 10'h000), "rel_second");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL provide port stall, input, 1 bit: hold fetch state and outputs.
REQ-004 SHALL provide port redirect, input, 1 bit: take branch/return, flush in-flight fetch.
REQ-005 SHALL provide port redirect_addr, input, 10 bits: new fetch address.
REQ-006 SHALL provide port int_req, input, 1 bit: level interrupt request.
REQ-007 SHALL provide port int_done, input, 1 bit: one-cycle pulse, interrupt service finished (RETIE).
REQ-008 SHALL provide port rom_instr, input, 18 bits: synchronous prog ROM data, one-cycle latency.
REQ-009 SHALL provide port rom_address, output, 10 bits: combinational address to prog ROM.
REQ-010 SHALL provide port instr_out, output, 18 bits: registered instruction to decode.
REQ-011 SHALL provide port addr_out, output, 10 bits: registered address of instr_out.
REQ-012 SHALL provide port valid_out, output, 1 bit: instr_out is a real instruction; 0 means NOP bubble.
REQ-013 SHALL provide port int_ack, output, 1 bit: one-cycle pulse on interrupt acceptance.
REQ-014 SHALL provide port int_ret_addr, output, 10 bits: registered return address captured on acceptance.

Function
REQ-015 SHALL hold registers fetch_pc (next address to fetch) and pc_delay (address whose data appears on rom_instr this cycle).
REQ-016 SHALL implement states FILL, RUN, INT_ACTIVE; priority in RUN/INT_ACTIVE: redirect > interrupt accept > stall > normal.
REQ-017 rom_address SHALL be: redirect_addr if redirect; 0x3FF if interrupt accepted this cycle; pc_delay if stall; else fetch_pc.
REQ-018 FILL (first cycle after reset release) SHALL: keep valid_out 0, set pc_delay<=fetch_pc, fetch_pc<=fetch_pc+1, go RUN; stall, redirect, int_req ignored.
REQ-019 Normal edge SHALL: instr_out<=rom_instr, addr_out<=pc_delay, valid_out<=1, pc_delay<=fetch_pc, fetch_pc<=fetch_pc+1.
REQ-020 Stall edge SHALL hold fetch_pc, pc_delay, instr_out, addr_out, valid_out unchanged.
REQ-021 Redirect edge SHALL: valid_out<=0, pc_delay<=redirect_addr, fetch_pc<=redirect_addr+1; instr_out/addr_out hold.
REQ-022 Interrupt SHALL be accepted when state RUN, int_req=1, redirect=0 (stall does not block).
REQ-023 Acceptance edge SHALL: int_ack<=1 for exactly one cycle, int_ret_addr<=pc_delay, valid_out<=0, pc_delay<=0x3FF, fetch_pc<=0x000, state INT_ACTIVE.
REQ-024 INT_ACTIVE SHALL fetch normally, ignore int_req, return to RUN on int_done; int_done in RUN ignored.
REQ-025 fetch_pc increment SHALL be 10-bit modulo: 0x3FF+1 = 0x000.
REQ-026 redirect coincident with int_done SHALL perform both (redirect and return to RUN).

Reset
REQ-027 rst_n=0 SHALL immediately force: fetch_pc=0, pc_delay=0, state FILL, instr_out=0, addr_out=0, valid_out=0, int_ack=0, int_ret_addr=0; rom_address=0.
REQ-028 Reset mid-stall, mid-redirect or in INT_ACTIVE SHALL discard all pending activity; first valid instruction after release SHALL be address 0x000, two edges after release.

Configuration
REQ-029 Macro FETCH_STAGE_INT_EN defined SHALL compile interrupt logic (REQ-022..024, 026).
REQ-030 Macro FETCH_STAGE_INT_EN undefined SHALL: ignore int_req and int_done, tie int_ack=0 and int_ret_addr=0, INT_ACTIVE unreachable; ports unchanged.

Verification
REQ-031 Release reset, ROM holds instr=address -> valid_out 0 on edge 1; edge 2 instr_out=0x00000, addr_out=0x000; edge 3 addr_out=0x001.
REQ-032 stall=1 for 3 cycles while addr_out=0x005 -> outputs hold 0x005 all 3 cycles, rom_address=0x006; after release addr_out=0x006, 0x007 with no skip or duplicate.
REQ-033 redirect=1, redirect_addr=0x120 while stall=1 -> next edge valid_out=0, following edge addr_out=0x120 valid_out=1, then 0x121.
REQ-034 With FETCH_STAGE_INT_EN, int_req=1 when pc_delay=0x040 -> int_ack one pulse, int_ret_addr=0x040, bubble, then addr_out=0x3FF, 0x000; held int_req causes no 2nd ack until int_done.
REQ-035 redirect_addr=0x3FE, run free -> addr_out 0x3FE, 0x3FF, 0x000 (wrap).
REQ-036 Without FETCH_STAGE_INT_EN, int_req held 1 for 20 cycles -> int_ack stays 0, sequential fetch unaffected.
